// File: rtl/wb_mem_sched.sv
// wb_mem_sched: multi-master to single-slave Wishbone scheduler with
// debug-priority / round-robin arbitration and a stalled-cycle watchdog.
module wb_mem_sched #(
  parameter int NM       = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 255,
  parameter int DBG_PRIO = 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NM*AW-1:0]   wbm_adr_i,
  input  logic [NM*DW-1:0]   wbm_dat_i,
  input  logic [NM*DW/8-1:0] wbm_sel_i,
  input  logic [NM-1:0]      wbm_we_i,
  input  logic [NM-1:0]      wbm_cyc_i,
  input  logic [NM-1:0]      wbm_stb_i,
  input  logic [NM*3-1:0]    wbm_cti_i,
  input  logic [NM*2-1:0]    wbm_bte_i,
  output logic [NM*DW-1:0]   wbm_dat_o,
  output logic [NM-1:0]      wbm_ack_o,
  output logic [NM-1:0]      wbm_err_o,
  output logic [NM-1:0]      wbm_rty_o,
  output logic [AW-1:0]      wbs_adr_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [DW/8-1:0]    wbs_sel_o,
  output logic               wbs_we_o,
  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  output logic [2:0]         wbs_cti_o,
  output logic [1:0]         wbs_bte_o,
  input  logic [DW-1:0]      wbs_dat_i,
  input  logic               wbs_ack_i,
  input  logic               wbs_err_i,
  input  logic               wbs_rty_i,
  output logic [NM-1:0]      grant_o,
  output logic               timeout_o
);
  localparam int OW = NM > 1 ? $clog2(NM) : 1;
  localparam logic [1:0] IDLE = 2'd0, OWN = 2'd1, ABORT = 2'd2, RELEASE = 2'd3;
  logic [1:0]    state;
  logic [OW-1:0] owner, pick;
  logic [OW:0]   idx;
  logic [15:0]   cnt;
  logic [NM-1:0] gm;
  logic          found, own, resp, stall;
  // Round-robin search starts just after the last owner; debug master overrides it.
  always_comb begin
    pick = owner;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NM; k++) begin
      idx = {1'b0, owner} + (OW+1)'(k);
      if (idx >= (OW+1)'(NM)) idx = idx - (OW+1)'(NM);
      if (!found && wbm_cyc_i[idx[OW-1:0]]) begin
        found = 1'b1;
        pick = idx[OW-1:0];
      end
    end
    if (DBG_PRIO == 1 && wbm_cyc_i[NM-1]) pick = OW'(NM-1);
  end
  assign own = state == OWN;
  always_comb begin
    wbs_adr_o = wbm_adr_i[owner*AW +: AW];
    wbs_dat_o = wbm_dat_i[owner*DW +: DW];
    wbs_sel_o = wbm_sel_i[owner*(DW/8) +: DW/8];
    wbs_cti_o = wbm_cti_i[owner*3 +: 3];
    wbs_bte_o = wbm_bte_i[owner*2 +: 2];
    wbs_we_o  = own & wbm_we_i[owner];
    wbs_cyc_o = own & wbm_cyc_i[owner];
    wbs_stb_o = own & wbm_stb_i[owner];
  end
  assign resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign stall     = wbs_stb_o & ~resp;
  assign grant_o   = state == IDLE ? '0 : NM'(1) << owner;
  assign gm        = wb_rst_i ? '0 : grant_o;
  assign wbm_ack_o = {NM{own & wbs_ack_i}} & gm;
  assign wbm_err_o = {NM{(own & wbs_err_i) | state == ABORT}} & gm;
  assign wbm_rty_o = {NM{own & wbs_rty_i}} & gm;
  assign wbm_dat_o = {NM{wbs_dat_i}};
  assign timeout_o = state == ABORT;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= OW'(NM-1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (|wbm_cyc_i) begin
          state <= OWN;
          owner <= pick;
        end
        OWN: if (!wbm_cyc_i[owner]) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (stall && cnt == 16'(TIMEOUT-1)) begin
          state <= ABORT;
          cnt   <= '0;
        end else if (resp) cnt <= '0;
        else if (stall) cnt <= cnt + 16'd1;
        ABORT: state <= RELEASE;
        default: if (!wbm_cyc_i[owner]) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_mem_sched.sv
// tb_wb_mem_sched: table-driven arbitration vectors plus burst, watchdog and reset sequences.
module tb_wb_mem_sched;
  localparam int NM = 3, AW = 32, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [NM*AW-1:0] adr;
  logic [NM*DW-1:0] mdat, mdat_o;
  logic [NM*DW/8-1:0] msel;
  logic [NM-1:0] we, cyc, stb, mack, merr, mrty, grant;
  logic [NM*3-1:0] cti;
  logic [NM*2-1:0] bte;
  logic [AW-1:0] sadr;
  logic [DW-1:0] sdat_o, sdat;
  logic [DW/8-1:0] ssel;
  logic swe, scyc, sstb, sack, serr, srty, tmo;
  logic [2:0] scti;
  logic [1:0] sbte;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  wb_mem_sched #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8), .DBG_PRIO(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(adr), .wbm_dat_i(mdat), .wbm_sel_i(msel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(mdat_o), .wbm_ack_o(mack), .wbm_err_o(merr), .wbm_rty_o(mrty),
    .wbs_adr_o(sadr), .wbs_dat_o(sdat_o), .wbs_sel_o(ssel), .wbs_we_o(swe),
    .wbs_cyc_o(scyc), .wbs_stb_o(sstb), .wbs_cti_o(scti), .wbs_bte_o(sbte),
    .wbs_dat_i(sdat), .wbs_ack_i(sack), .wbs_err_i(serr), .wbs_rty_i(srty),
    .grant_o(grant), .timeout_o(tmo)
  );
  typedef struct {
    logic rst;
    logic [2:0] cyc;
    logic ack, err;
    logic [2:0] g, a, e;
    logic c;
  } vec_t;
  vec_t tbl [24];
  function automatic vec_t v(logic r, logic [2:0] c, logic a, logic e,
                             logic [2:0] g, logic [2:0] ea, logic [2:0] ee, logic sc);
    vec_t x;
    x.rst = r; x.cyc = c; x.ack = a; x.err = e; x.g = g; x.a = ea; x.e = ee; x.c = sc;
    return x;
  endfunction
  task automatic chk(string n, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic drv(logic r, logic [2:0] c, logic a, logic e, logic [2:0] ct1);
    @(negedge clk);
    rst = r; cyc = c; stb = c; sack = a; serr = e;
    cti = {3'b000, ct1, 3'b000};
    #1;
  endtask
  initial begin
    adr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    mdat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    msel = '1; we = '0; cyc = '0; stb = '0; cti = '0; bte = '0;
    sdat = 32'hCAFE_0001; sack = 1'b0; serr = 1'b0; srty = 1'b0;
    //             rst cyc   ack err  grant   ack     err     scyc
    tbl[0]  = v(1, 3'b000, 1, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[1]  = v(0, 3'b000, 1, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[2]  = v(0, 3'b011, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[3]  = v(0, 3'b011, 1, 0, 3'b001, 3'b001, 3'b000, 1);
    tbl[4]  = v(0, 3'b010, 0, 0, 3'b001, 3'b000, 3'b000, 0);
    tbl[5]  = v(0, 3'b011, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[6]  = v(0, 3'b011, 1, 0, 3'b010, 3'b010, 3'b000, 1);
    tbl[7]  = v(0, 3'b001, 0, 0, 3'b010, 3'b000, 3'b000, 0);
    tbl[8]  = v(0, 3'b011, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[9]  = v(0, 3'b011, 1, 0, 3'b001, 3'b001, 3'b000, 1);
    tbl[10] = v(0, 3'b010, 0, 0, 3'b001, 3'b000, 3'b000, 0);
    tbl[11] = v(0, 3'b011, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[12] = v(0, 3'b011, 1, 0, 3'b010, 3'b010, 3'b000, 1);
    tbl[13] = v(0, 3'b001, 0, 0, 3'b010, 3'b000, 3'b000, 0);
    tbl[14] = v(0, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[15] = v(0, 3'b101, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[16] = v(0, 3'b101, 0, 0, 3'b100, 3'b000, 3'b000, 1);
    tbl[17] = v(0, 3'b101, 1, 0, 3'b100, 3'b100, 3'b000, 1);
    tbl[18] = v(0, 3'b001, 0, 0, 3'b100, 3'b000, 3'b000, 0);
    tbl[19] = v(0, 3'b001, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    tbl[20] = v(0, 3'b001, 1, 0, 3'b001, 3'b001, 3'b000, 1);
    tbl[21] = v(0, 3'b001, 0, 1, 3'b001, 3'b000, 3'b001, 1);
    tbl[22] = v(0, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 0);
    tbl[23] = v(0, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    for (int i = 0; i < 24; i++) begin
      drv(tbl[i].rst, tbl[i].cyc, tbl[i].ack, tbl[i].err, 3'b000);
      chk($sformatf("r%0d_grant", i), 96'(grant), 96'(tbl[i].g));
      chk($sformatf("r%0d_ack", i), 96'(mack), 96'(tbl[i].a));
      chk($sformatf("r%0d_err", i), 96'(merr), 96'(tbl[i].e));
      chk($sformatf("r%0d_scyc", i), 96'(scyc), 96'(tbl[i].c));
      chk($sformatf("r%0d_timeout", i), 96'(tmo), 96'(0));
    end
    chk("dat_bcast", 96'(mdat_o), {3{32'hCAFE_0001}});
    // Burst from master 1 while master 0 waits.
    drv(0, 3'b011, 0, 0, 3'b010);
    chk("burst_idle_grant", 96'(grant), 96'(3'b000));
    for (int k = 0; k < 4; k++) begin
      drv(0, 3'b011, 1, 0, k < 3 ? 3'b010 : 3'b111);
      chk($sformatf("burst%0d_grant", k), 96'(grant), 96'(3'b010));
      chk($sformatf("burst%0d_ack", k), 96'(mack), 96'(3'b010));
      chk($sformatf("burst%0d_cti", k), 96'(scti), k < 3 ? 96'(3'b010) : 96'(3'b111));
      chk($sformatf("burst%0d_adr", k), 96'(sadr), 96'(32'h0000_2000));
    end
    drv(0, 3'b001, 0, 0, 3'b000);
    chk("burst_end_scyc", 96'(scyc), 96'(0));
    drv(0, 3'b001, 0, 0, 3'b000);
    chk("burst_dead_grant", 96'(grant), 96'(3'b000));
    drv(0, 3'b001, 0, 0, 3'b000);
    chk("burst_next_grant", 96'(grant), 96'(3'b001));
    drv(0, 3'b000, 0, 0, 3'b000);
    // Watchdog: slave never responds.
    drv(0, 3'b001, 0, 0, 3'b000);
    chk("wd_idle_grant", 96'(grant), 96'(3'b000));
    for (int k = 0; k < 8; k++) begin
      drv(0, 3'b001, 0, 0, 3'b000);
      chk($sformatf("wd%0d_scyc", k), 96'(scyc), 96'(1));
      chk($sformatf("wd%0d_err", k), 96'(merr), 96'(3'b000));
      chk($sformatf("wd%0d_timeout", k), 96'(tmo), 96'(0));
    end
    drv(0, 3'b001, 0, 0, 3'b000);
    chk("abort_scyc", 96'(scyc), 96'(0));
    chk("abort_sstb", 96'(sstb), 96'(0));
    chk("abort_err", 96'(merr), 96'(3'b001));
    chk("abort_timeout", 96'(tmo), 96'(1));
    chk("abort_grant", 96'(grant), 96'(3'b001));
    drv(0, 3'b001, 1, 0, 3'b000);
    chk("release_scyc", 96'(scyc), 96'(0));
    chk("release_ack", 96'(mack), 96'(3'b000));
    chk("release_err", 96'(merr), 96'(3'b000));
    chk("release_timeout", 96'(tmo), 96'(0));
    chk("release_grant", 96'(grant), 96'(3'b001));
    drv(0, 3'b000, 0, 0, 3'b000);
    chk("release_hold_grant", 96'(grant), 96'(3'b001));
    drv(0, 3'b000, 0, 0, 3'b000);
    chk("release_idle_grant", 96'(grant), 96'(3'b000));
    // Reset in the middle of an owned transfer.
    drv(0, 3'b010, 0, 0, 3'b000);
    drv(0, 3'b010, 0, 0, 3'b000);
    chk("rst_pre_scyc", 96'(scyc), 96'(1));
    chk("rst_pre_grant", 96'(grant), 96'(3'b010));
    drv(1, 3'b010, 1, 0, 3'b000);
    chk("rst_in_ack", 96'(mack), 96'(3'b000));
    chk("rst_in_err", 96'(merr), 96'(3'b000));
    drv(0, 3'b011, 0, 0, 3'b000);
    chk("rst_post_scyc", 96'(scyc), 96'(0));
    chk("rst_post_grant", 96'(grant), 96'(3'b000));
    chk("rst_post_err", 96'(merr), 96'(3'b000));
    drv(0, 3'b011, 0, 0, 3'b000);
    chk("rst_first_grant", 96'(grant), 96'(3'b001));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_mem_sched.md
WB_MEM_SCHED -- requirements
Module: wb_mem_sched

Interface
REQ-001 SHALL have parameter NM, default 3: number of masters; master NM-1 is the debug port.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width, multiple of 8.
REQ-004 SHALL have parameter TIMEOUT, default 255: stalled-cycle limit, range 1..65535.
REQ-005 SHALL have parameter DBG_PRIO, default 1: 1 gives master NM-1 fixed priority over the others.
REQ-006 SHALL use one clock and a synchronous, active-high reset; port names wb_clk_i and wb_rst_i.
REQ-007 SHALL have ports: wb_clk_i  in  1  clock; wb_rst_i  in  1  synchronous active-high reset.
REQ-008 SHALL have master-side inputs, packed with master i at slice i:
- wbm_adr_i  in  NM*AW
- wbm_dat_i  in  NM*DW
- wbm_sel_i  in  NM*DW/8
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NM each
- wbm_cti_i  in  NM*3
- wbm_bte_i  in  NM*2
REQ-009 SHALL have master-side outputs: wbm_dat_o  out  NM*DW; wbm_ack_o, wbm_err_o, wbm_rty_o  out  NM each.
REQ-010 SHALL have slave-side outputs: wbs_adr_o AW, wbs_dat_o DW, wbs_sel_o DW/8, wbs_we_o 1, wbs_cyc_o 1, wbs_stb_o 1, wbs_cti_o 3, wbs_bte_o 2.
REQ-011 SHALL have slave-side inputs: wbs_dat_i DW, wbs_ack_i 1, wbs_err_i 1, wbs_rty_i 1.
REQ-012 SHALL have status outputs: grant_o  out  NM  one-hot current owner; timeout_o  out  1  one-cycle watchdog pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, OWN, ABORT and RELEASE.
REQ-014 IDLE: when any wbm_cyc_i is high, SHALL register the owner and enter OWN on the next edge; wbs_cyc_o goes high one cycle after the request is seen.
REQ-015 Owner selection: if DBG_PRIO=1 and wbm_cyc_i[NM-1] is high, the owner SHALL be NM-1; otherwise the owner SHALL be round-robin, starting at the index after the last owner and wrapping NM-1 to 0.
REQ-016 OWN: SHALL route all owner request signals combinationally to wbs_*.
REQ-017 OWN: SHALL return wbs_ack_i, wbs_err_i and wbs_rty_i only on the owner's slice; all other masters' ack, err and rty SHALL be 0.
REQ-018 wbm_dat_o SHALL broadcast wbs_dat_i to every slice.
REQ-019 The owner SHALL be held until its cyc drops, so bursts and locked cycles (cti 001/010) are never split.
REQ-020 When the owner's cyc drops, the block SHALL return to IDLE; exactly one dead cycle occurs between owners.
REQ-021 Watchdog: a 16-bit counter SHALL increment each OWN cycle with wbs_stb_o=1 and no ack, err or rty.
REQ-022 The watchdog counter SHALL clear on any slave response and on every state exit.
REQ-023 When the counter equals TIMEOUT, the block SHALL enter ABORT.
REQ-024 ABORT lasts one cycle: wbs_cyc_o=wbs_stb_o=0, owner wbm_err_o=1, timeout_o=1; next state is RELEASE.
REQ-025 RELEASE: wbs_cyc_o=0, all responses 0; the block SHALL remain until the owner's cyc is low, then enter IDLE.
REQ-026 Outside OWN, wbs_cyc_o, wbs_stb_o and wbs_we_o SHALL be 0; other wbs_* outputs are don't-care.
REQ-027 A slave response arriving in IDLE, ABORT or RELEASE SHALL be ignored.

Reset
REQ-028 On wb_rst_i high at a clock edge: state=IDLE, grant_o=0, counter=0, timeout_o=0, last owner=NM-1 (so master 0 wins first round-robin).
REQ-029 Reset asserted mid-transfer SHALL drop wbs_cyc_o the following cycle with no err or ack to any master.
REQ-030 All master-side responses SHALL be 0 while in reset.

Verification
REQ-031 Masters 0 and 1 hold cyc continuously, each transfer acked, each master dropping cyc for one cycle after its ack -> grants alternate 0,1,0,1 with one idle cycle between.
REQ-032 DBG_PRIO=1, masters 0 and 2 request in the same cycle -> grant_o=3'b100; master 0 granted only after master 2 drops cyc.
REQ-033 Master 1 issues a 4-beat incrementing burst (cti 010...111) while master 0 requests -> all 4 acks go to master 1 before grant_o=3'b001.
REQ-034 TIMEOUT=8, slave never acks -> after 8 stalled cycles, one-cycle wbm_err_o on the owner plus a timeout_o pulse, and wbs_cyc_o low from that cycle.
REQ-035 Reset asserted during OWN with stb high -> wbs_cyc_o=0 next cycle, grant_o=0; the first post-reset grant goes to master 0.
REQ-036 wbs_ack_i pulsed in IDLE -> all wbm_ack_o remain 0.
